ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder_if.sv | 22 ++
 rtl/ps2_key_decoder.sv | 147 ++++++++++++++
 tb/tb_ps2_key_decoder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
// Purpose : groups the byte-input strobe and the event-FIFO read port of ps2_key_decoder.
// Ports   : in_valid/in_data/in_parity_ok (received byte), ev_valid/ev_data/ev_count/ev_pop (event FIFO head).
// Modports: master = byte source / event consumer, slave = the decoder itself.
interface ps2_key_decoder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_parity_ok;
  logic       ev_valid;
  logic [9:0] ev_data;   // {ext, rel, code[7:0]}
  logic       ev_pop;
  logic [3:0] ev_count;

  modport master (
    output in_valid, in_data, in_parity_ok, ev_pop,
    input  ev_valid, ev_data, ev_count
  );

  modport slave (
    input  in_valid, in_data, in_parity_ok, ev_pop,
    output ev_valid, ev_data, ev_count
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// Purpose : PS/2 set-2 scancode decoder; turns make/break/extended/pause byte sequences into {ext,rel,code} events in an 8-deep FWFT FIFO.
// Latency : event visible on ev_valid/ev_data the cycle after the in_valid edge that completes it.
// Backpressure: none on input (every in_valid accepted); a full FIFO drops the event and sets sticky ovf_o.
// Ports   : clk_i, rst_i (sync, active-high), clr_flags_i, err_o, ovf_o, bus (ps2_key_decoder_if.slave).
module ps2_key_decoder (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_flags_i,
  output logic                     err_o,
  output logic                     ovf_o,
  ps2_key_decoder_if.slave         bus
);

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_E0    = 3'd1,
    ST_F0    = 3'd2,
    ST_E0F0  = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       push;
  logic [9:0] push_dat;
  logic       err_set;

  logic [9:0] mem_q [8];
  logic [2:0] wr_ptr_q, rd_ptr_q;
  logic [3:0] count_q, count_d;
  logic       err_q, ovf_q;
  logic       do_pop, do_push, ovf_set;

  // Decoder next-state / push generation
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    push     = 1'b0;
    push_dat = 10'd0;
    err_set  = 1'b0;
    if (bus.in_valid) begin
      if (!bus.in_parity_ok) begin
        err_set = 1'b1;
        state_d = ST_IDLE;
        skip_d  = 3'd0;
      end else if (bus.in_data == BYTE_00 || bus.in_data == BYTE_FF) begin
        // keyboard overrun codes abort whatever sequence was in progress
        err_set = 1'b1;
        state_d = ST_IDLE;
        skip_d  = 3'd0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (bus.in_data == BYTE_E0) begin
              state_d = ST_E0;
            end else if (bus.in_data == BYTE_F0) begin
              state_d = ST_F0;
            end else if (bus.in_data == BYTE_E1) begin
              state_d = ST_PAUSE;
              skip_d  = 3'd7;
            end else begin
              push     = 1'b1;
              push_dat = {2'b00, bus.in_data};
            end
          end
          ST_E0: begin
            if (bus.in_data == BYTE_F0) begin
              state_d = ST_E0F0;
            end else if (bus.in_data != BYTE_E0) begin
              push     = 1'b1;
              push_dat = {2'b10, bus.in_data};
              state_d  = ST_IDLE;
            end
          end
          ST_F0, ST_E0F0: begin
            state_d = ST_IDLE;
            if (bus.in_data == BYTE_E0 || bus.in_data == BYTE_F0 || bus.in_data == BYTE_E1) begin
              err_set = 1'b1;
            end else begin
              push     = 1'b1;
              push_dat = {(state_q == ST_E0F0), 1'b1, bus.in_data};
            end
          end
          ST_PAUSE: begin
            // the 7 trailing pause bytes are not decoded, only counted
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) begin
              push     = 1'b1;
              push_dat = {2'b10, 8'h77};
              state_d  = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // FIFO control: a pop on empty is ignored; a pop at full frees the slot for a same-cycle push
  always_comb begin
    do_pop  = bus.ev_pop && (count_q != 4'd0);
    do_push = push && ((count_q != 4'd8) || do_pop);
    ovf_set = push && !do_push;
    count_d = count_q + {3'd0, do_push} - {3'd0, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      skip_q   <= 3'd0;
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 3'd1;
      // a new event in the same cycle as clr_flags keeps the flag set
      if (err_set)          err_q <= 1'b1;
      else if (clr_flags_i) err_q <= 1'b0;
      if (ovf_set)          ovf_q <= 1'b1;
      else if (clr_flags_i) ovf_q <= 1'b0;
    end
  end

  // Storage carries no reset; only pointer/count state decides what is valid
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_ptr_q] <= push_dat;
  end

  assign bus.ev_valid = (count_q != 4'd0);
  assign bus.ev_data  = mem_q[rd_ptr_q];
  assign bus.ev_count = count_q;
  assign err_o        = err_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Purpose : directed self-checking bench for ps2_key_decoder.
// Ports   : none; drives the DUT through a ps2_key_decoder_if instance.
// Timing  : inputs change and outputs are sampled on the falling clock edge.
module tb_ps2_key_decoder;
  logic clk;
  logic rst;
  logic clr_flags;
  logic err;
  logic ovf;
  int   vectors;
  int   miscompares;

  ps2_key_decoder_if bus ();

  ps2_key_decoder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_flags_i (clr_flags),
    .err_o       (err),
    .ovf_o       (ovf),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks are entered and left on a falling edge.
  task automatic send_byte(input logic [7:0] b, input logic par);
    bus.in_valid     = 1'b1;
    bus.in_data      = b;
    bus.in_parity_ok = par;
    @(negedge clk);
    bus.in_valid     = 1'b0;
    bus.in_parity_ok = 1'b1;
  endtask

  task automatic pop_one();
    bus.ev_pop = 1'b1;
    @(negedge clk);
    bus.ev_pop = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    // reset overrides simultaneous input, pop and clear
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h1C; bus.ev_pop = 1'b1; clr_flags = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0; bus.ev_pop = 1'b0; clr_flags = 1'b0;
    vectors++; if (bus.ev_valid !== 1'b0) begin $display("FAIL reset_ev_valid got %b want 0", bus.ev_valid); miscompares++; end
    vectors++; if (bus.ev_count !== 4'd0) begin $display("FAIL reset_count got %0d want 0", bus.ev_count); miscompares++; end
    vectors++; if ({err, ovf} !== 2'b00) begin $display("FAIL reset_flags got %b want 00", {err, ovf}); miscompares++; end
  endtask

  task automatic test_make_break();
    send_byte(8'h1C, 1'b1);
    vectors++; if (bus.ev_valid !== 1'b1 || bus.ev_data !== 10'h01C) begin $display("FAIL make_latency got v=%b d=%h want v=1 d=01c", bus.ev_valid, bus.ev_data); miscompares++; end
    send_byte(8'hF0, 1'b1);
    send_byte(8'h1C, 1'b1);
    vectors++; if (bus.ev_count !== 4'd2) begin $display("FAIL mb_count got %0d want 2", bus.ev_count); miscompares++; end
    vectors++; if (err !== 1'b0) begin $display("FAIL mb_err got %b want 0", err); miscompares++; end
    vectors++; if (bus.ev_data !== 10'h01C) begin $display("FAIL mb_make got %h want 01c", bus.ev_data); miscompares++; end
    pop_one();
    vectors++; if (bus.ev_data !== 10'h11C) begin $display("FAIL mb_break got %h want 11c", bus.ev_data); miscompares++; end
    pop_one();
    vectors++; if (bus.ev_valid !== 1'b0) begin $display("FAIL mb_drained got %b want 0", bus.ev_valid); miscompares++; end
  endtask

  task automatic test_extended();
    send_byte(8'hE0, 1'b1);
    send_byte(8'hE0, 1'b1);   // repeated prefix: stays extended, nothing pushed
    send_byte(8'h75, 1'b1);
    send_byte(8'hE0, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'h75, 1'b1);
    vectors++; if (bus.ev_count !== 4'd2) begin $display("FAIL ext_count got %0d want 2", bus.ev_count); miscompares++; end
    vectors++; if (bus.ev_data !== 10'h275) begin $display("FAIL ext_make got %h want 275", bus.ev_data); miscompares++; end
    pop_one();
    vectors++; if (bus.ev_data !== 10'h375) begin $display("FAIL ext_break got %h want 375", bus.ev_data); miscompares++; end
    pop_one();
  endtask

  task automatic test_back_to_back_pause();
    logic [7:0] seq [9];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
    // one in_valid pulse per consecutive cycle
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1; bus.in_data = seq[i]; bus.in_parity_ok = 1'b1;
      @(negedge clk);
      if (i == 7) begin
        vectors++; if (bus.ev_count !== 4'd1 || bus.ev_data !== 10'h277) begin $display("FAIL pause_event got n=%0d d=%h want n=1 d=277", bus.ev_count, bus.ev_data); miscompares++; end
      end
    end
    bus.in_valid = 1'b0;
    vectors++; if (bus.ev_count !== 4'd2) begin $display("FAIL pause_count got %0d want 2", bus.ev_count); miscompares++; end
    pop_one();
    vectors++; if (bus.ev_data !== 10'h01C) begin $display("FAIL pause_after got %h want 01c", bus.ev_data); miscompares++; end
    pop_one();
  endtask

  task automatic test_errors();
    send_byte(8'hE0, 1'b1);
    send_byte(8'h75, 1'b0);
    vectors++; if (bus.ev_count !== 4'd0) begin $display("FAIL parity_nopush got %0d want 0", bus.ev_count); miscompares++; end
    vectors++; if (err !== 1'b1) begin $display("FAIL parity_err got %b want 1", err); miscompares++; end
    send_byte(8'h75, 1'b1);
    vectors++; if (bus.ev_data !== 10'h075) begin $display("FAIL parity_idle got %h want 075", bus.ev_data); miscompares++; end
    pop_one();
    pulse_clr();
    vectors++; if (err !== 1'b0) begin $display("FAIL clr_err got %b want 0", err); miscompares++; end
    // overrun byte mid-sequence aborts it
    send_byte(8'hE0, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h75, 1'b1);
    vectors++; if (err !== 1'b1 || bus.ev_count !== 4'd1 || bus.ev_data !== 10'h075) begin $display("FAIL overrun got e=%b n=%0d d=%h want e=1 n=1 d=075", err, bus.ev_count, bus.ev_data); miscompares++; end
    pop_one();
    // illegal byte after F0
    pulse_clr();
    send_byte(8'hF0, 1'b1);
    send_byte(8'hE1, 1'b1);
    vectors++; if (err !== 1'b1 || bus.ev_count !== 4'd0) begin $display("FAIL f0_bad got e=%b n=%0d want e=1 n=0", err, bus.ev_count); miscompares++; end
    // set wins over clear
    pulse_clr();
    clr_flags = 1'b1;
    send_byte(8'hFF, 1'b1);
    clr_flags = 1'b0;
    vectors++; if (err !== 1'b1) begin $display("FAIL set_wins got %b want 1", err); miscompares++; end
    pulse_clr();
  endtask

  task automatic test_overflow();
    pulse_rst();
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 1'b1);
    vectors++; if (bus.ev_count !== 4'd8) begin $display("FAIL ovf_count got %0d want 8", bus.ev_count); miscompares++; end
    vectors++; if (ovf !== 1'b1) begin $display("FAIL ovf_flag got %b want 1", ovf); miscompares++; end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (bus.ev_valid !== 1'b1 || bus.ev_data !== 10'h010 + 10'(i)) begin $display("FAIL ovf_pop%0d got v=%b d=%h want v=1 d=%h", i, bus.ev_valid, bus.ev_data, 10'h010 + 10'(i)); miscompares++; end
      pop_one();
    end
    vectors++; if (bus.ev_valid !== 1'b0) begin $display("FAIL ovf_empty got %b want 0", bus.ev_valid); miscompares++; end
    for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i), 1'b1);
    pulse_clr();
    bus.ev_pop = 1'b1;
    send_byte(8'h28, 1'b1);
    bus.ev_pop = 1'b0;
    vectors++; if (bus.ev_count !== 4'd8 || ovf !== 1'b0) begin $display("FAIL full_pushpop got n=%0d o=%b want n=8 o=0", bus.ev_count, ovf); miscompares++; end
    vectors++; if (bus.ev_data !== 10'h021) begin $display("FAIL full_head got %h want 021", bus.ev_data); miscompares++; end
    pulse_rst();
    pop_one();
    vectors++; if (bus.ev_count !== 4'd0 || bus.ev_valid !== 1'b0) begin $display("FAIL empty_pop got n=%0d v=%b want n=0 v=0", bus.ev_count, bus.ev_valid); miscompares++; end
    bus.ev_pop = 1'b1;
    send_byte(8'h33, 1'b1);
    bus.ev_pop = 1'b0;
    vectors++; if (bus.ev_count !== 4'd1 || bus.ev_data !== 10'h033) begin $display("FAIL empty_pushpop got n=%0d d=%h want n=1 d=033", bus.ev_count, bus.ev_data); miscompares++; end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h00, 1'b1);   // leave err set so reset must clear it
    send_byte(8'hF0, 1'b1);
    pulse_rst();
    send_byte(8'h1C, 1'b1);
    vectors++; if (bus.ev_count !== 4'd1 || bus.ev_data !== 10'h01C) begin $display("FAIL rst_mid got n=%0d d=%h want n=1 d=01c", bus.ev_count, bus.ev_data); miscompares++; end
    vectors++; if ({err, ovf} !== 2'b00) begin $display("FAIL rst_mid_flags got %b want 00", {err, ovf}); miscompares++; end
    // reset inside a pause sequence
    pulse_rst();
    send_byte(8'hE1, 1'b1);
    send_byte(8'h14, 1'b1);
    pulse_rst();
    send_byte(8'h77, 1'b1);
    vectors++; if (bus.ev_count !== 4'd1 || bus.ev_data !== 10'h077) begin $display("FAIL rst_pause got n=%0d d=%h want n=1 d=077", bus.ev_count, bus.ev_data); miscompares++; end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    clr_flags        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = 8'h00;
    bus.in_parity_ok = 1'b1;
    bus.ev_pop       = 1'b0;
    @(negedge clk);
    test_reset();
    test_make_break();
    test_extended();
    test_back_to_back_pause();
    test_errors();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
